frame_collector: RTL and testbench
==================================

# frame_collector

Sink-side reorder buffer for the pixel stream emitted by the geometry blocks (mirror, rotate, crop). It accepts pixels tagged with arbitrary `(count_x, count_y)` coordinates and stores each one at its tagged position in an on-chip frame buffer. Once a full frame has been accepted, it re-emits the frame in strict raster order using the same stream protocol. It sits between a coordinate-scrambling stage and any consumer that requires raster order, such as a line-buffered filter or an output writer.

## Interface
Parameters:
- `data_width`, 8, pixel width
- `im_width`, 320, frame width in pixels
- `im_height`, 464, frame height in pixels
- `im_width_bits`, 9, width of the x/y coordinate buses

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_enable`  in  1  input pixel valid
- `in_data`  in  `data_width`  input pixel
- `in_count_x`  in  `im_width_bits`  target column of input pixel
- `in_count_y`  in  `im_width_bits`  target row of input pixel
- `out_ready`  out  1  output pixel valid
- `out_data`  out  `data_width`  output pixel
- `out_count_x`  out  `im_width_bits`  raster column of output pixel
- `out_count_y`  out  `im_width_bits`  raster row of output pixel
- `busy`  out  1  high while draining; input is ignored
- `frame_done`  out  1  one-cycle pulse coincident with the last output pixel

## Operation
- Two states: COLLECT and DRAIN. Reset enters COLLECT with the accept counter at 0.
- COLLECT, when `in_enable`=1:
  - If `in_count_x < im_width` and `in_count_y < im_height`, write `in_data` to address `y*im_width + x` and increment the accept counter.
  - Otherwise, drop the pixel without counting it.
- Duplicate coordinates are counted each time they are accepted; the last write wins.
- When the accept counter reaches `N = im_width*im_height`, go to DRAIN on the next cycle and clear the counter.
- DRAIN:
  - Read addresses 0..N-1, one per cycle.
  - The x/y raster counters track the read address: x wraps at `im_width-1` and increments y.
  - `in_enable` is ignored. Ignored pixels are neither written nor counted.
- After address N-1 is issued, return to COLLECT. Returning to COLLECT and the last output beat happen together.
- Address arithmetic is unsigned and wide enough for N-1. The counter is `$clog2(N+1)` bits wide, which is 18 bits at the default size.
- Frame buffer contents are not cleared by reset or between frames. Unwritten positions re-emit stale data.

## Timing
- Reset values: `out_ready`=0, `out_data`=0, `out_count_x`=0, `out_count_y`=0, `busy`=0, `frame_done`=0.
- Write path: a pixel is written in the same cycle `in_enable` is sampled. The N-th accepted pixel causes `busy`=1 from the next cycle.
- Read latency is 1 cycle (synchronous RAM).
  - Address k is issued on DRAIN cycle k.
  - `out_ready`=1 with pixel k on cycle k+1.
  - Output is a contiguous burst of exactly N beats with no gaps.
- `out_count_x`/`out_count_y` are registered alongside `out_data` and match the pixel emitted.
- `frame_done`=1 only on the beat carrying `(im_width-1, im_height-1)`.
- `busy` deasserts the same cycle as that last beat. An input pixel presented on that cycle is accepted into the next frame.
- The block accepts at most one pixel per cycle, and gaps in `in_enable` are allowed.
- Asynchronous reset mid-frame (either state):
  - All outputs drop to their reset values immediately.
  - The counter clears and the state returns to COLLECT.
  - A partial burst is not resumed.

## Structure
- A shared image package holds the pixel-count constant `N`, the counter width function, and the COLLECT/DRAIN state encoding.
- One sub-module, `fb_ram`: a single-port synchronous RAM with N words of `data_width` bits, write-first. A single port is enough because writes (COLLECT) and reads (DRAIN) never overlap.
- The top level holds the FSM, the accept counter, the raster counters, and the output registers.

## Test plan
Use small parameters: `im_width`=4, `im_height`=3, `im_width_bits`=3.
- Raster input with `data = 4y + x` → after 12 accepts, `busy`=1; 12 contiguous beats with data 0..11 and counts (0,0)..(3,2); `frame_done` only on (3,2).
- Horizontally mirrored coordinates (`x' = 3-x`, `data = 4y + x`) → output beat k carries data `4(k/4) + 3 - k%4` at raster position k.
- Input with coordinate (4,1) or (0,3) inserted → no write and no count; drain starts only after 12 in-range pixels.
- `in_enable` held high with data 0xFF throughout DRAIN → output unaffected; next frame's counter starts at 0; 0xFF appears nowhere in frame 2.
- `rst_n` pulsed low at drain beat 5 → `out_ready`/`busy`/`frame_done` are 0 during reset; after release, 12 new pixels are required before the next burst.
- Pixels spaced by random 0–3 idle cycles → identical output to scenario 1.

Source files
------------

// File: rtl/frame_collector_pkg.sv
// Shared image constants, counter sizing and the collect/drain state encoding
// for the raster reorder buffer.
package frame_collector_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  localparam int N_PIX = 320 * 464;

  function automatic int pix_count(input int w, input int h);
    return w * h;
  endfunction

  // Accept counter must be able to hold N itself, not just N-1.
  function automatic int cnt_bits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/frame_collector_fb_ram.sv
// Single-port synchronous frame buffer, one-cycle read latency, write-first.
module fb_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata_q   <= wdata;
    end else begin
      rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frame_collector.sv
// Collects a frame of coordinate-tagged pixels in any order, then re-emits it
// as one contiguous raster-order burst.
module frame_collector
  import frame_collector_pkg::*;
#(
  parameter int data_width    = 8,
  parameter int im_width      = 320,
  parameter int im_height     = 464,
  parameter int im_width_bits = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_enable,
  input  logic [data_width-1:0]    in_data,
  input  logic [im_width_bits-1:0] in_count_x,
  input  logic [im_width_bits-1:0] in_count_y,
  output logic                     out_ready,
  output logic [data_width-1:0]    out_data,
  output logic [im_width_bits-1:0] out_count_x,
  output logic [im_width_bits-1:0] out_count_y,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int N  = pix_count(im_width, im_height);
  localparam int CW = cnt_bits(N);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]            LAST  = CW'(N - 1);
  localparam logic [im_width_bits:0]   W_LIM = (im_width_bits + 1)'(im_width);
  localparam logic [im_width_bits:0]   H_LIM = (im_width_bits + 1)'(im_height);
  localparam logic [im_width_bits-1:0] X_MAX = im_width_bits'(im_width - 1);

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [im_width_bits-1:0] rx_q, rx_d, ry_q, ry_d;
  logic                     out_ready_q, out_ready_d;
  logic [im_width_bits-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     in_range, last_rd;
  logic [CW-1:0]            wr_lin;
  logic                     ram_we;
  logic [AW-1:0]            ram_addr;
  logic [data_width-1:0]    ram_rdata;

  assign in_range = ({1'b0, in_count_x} < W_LIM) && ({1'b0, in_count_y} < H_LIM);
  assign wr_lin   = CW'(in_count_y) * CW'(im_width) + CW'(in_count_x);
  assign last_rd  = (state_q == DRAIN) && (cnt_q == LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
    ram_we   = 1'b0;
    ram_addr = AW'(wr_lin);
    case (state_q)
      COLLECT: begin
        if (in_enable && in_range) begin
          ram_we = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        ram_addr = AW'(cnt_q);
        if (last_rd) begin
          cnt_d   = '0;
          rx_d    = '0;
          ry_d    = '0;
          state_d = COLLECT;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (rx_q == X_MAX) begin
            rx_d = '0;
            ry_d = ry_q + 1'b1;
          end else begin
            rx_d = rx_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Output registers lag the read address by one cycle, matching the RAM.
  always_comb begin
    out_ready_d = (state_q == DRAIN);
    out_x_d     = (state_q == DRAIN) ? rx_q : out_x_q;
    out_y_d     = (state_q == DRAIN) ? ry_q : out_y_q;
    done_d      = last_rd;
    busy_d      = (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      out_ready_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      out_ready_q <= out_ready_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  fb_ram #(
    .DW    (data_width),
    .DEPTH (N),
    .AW    (AW)
  ) u_fb_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (in_data),
    .rdata (ram_rdata)
  );

  // RAM read register is unreset; gating keeps out_data at 0 outside a burst.
  assign out_data    = out_ready_q ? ram_rdata : '0;
  assign out_ready   = out_ready_q;
  assign out_count_x = out_x_q;
  assign out_count_y = out_y_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_frame_collector.sv
// Randomized bench for frame_collector at 4x3: a frame-level model holds the
// expected buffer image and every burst is compared beat by beat against it.
module tb_frame_collector;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int NP = W * H;

  logic       clk, rst_n;
  logic       in_enable;
  logic [7:0] in_data;
  logic [2:0] in_count_x, in_count_y;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_count_x, out_count_y;
  logic       busy, frame_done;

  frame_collector #(
    .data_width    (8),
    .im_width      (W),
    .im_height     (H),
    .im_width_bits (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_enable   (in_enable),
    .in_data     (in_data),
    .in_count_x  (in_count_x),
    .in_count_y  (in_count_y),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_count_x (out_count_x),
    .out_count_y (out_count_y),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_m [NP];
  int qx[$], qy[$], qd[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_flood(input bit flood);
    if (flood) begin
      in_enable  = 1'b1;
      in_data    = 8'hFF;
      in_count_x = 3'($urandom_range(W - 1, 0));
      in_count_y = 3'($urandom_range(H - 1, 0));
    end else begin
      in_enable = 1'b0;
    end
  endtask

  // Feeds queued pixels until NP in-range pixels have been accepted.
  task automatic send_frame(input int gap_max);
    int acc;
    acc = 0;
    while (qx.size() > 0 && acc < NP) begin
      int x, y, d, g;
      x = qx.pop_front();
      y = qy.pop_front();
      d = qd.pop_front();
      g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      repeat (g) begin
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || out_ready !== 1'b0) begin
          bad++;
          $display("FAIL collect_gap: busy=%b out_ready=%b, want 0 0", busy, out_ready);
        end
        in_enable = 1'b0;
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || out_ready !== 1'b0) begin
        bad++;
        $display("FAIL collect_busy: acc=%0d busy=%b out_ready=%b, want 0 0", acc, busy, out_ready);
      end
      in_enable  = 1'b1;
      in_count_x = 3'(x);
      in_count_y = 3'(y);
      in_data    = 8'(d);
      if (x < W && y < H) begin
        mem_m[y * W + x] = 8'(d);
        acc++;
      end
    end
    qx.delete(); qy.delete(); qd.delete();
  endtask

  task automatic drain_check(input bit flood);
    int w;
    logic [16:0] got, exp;
    w = 0;
    @(negedge clk);
    drive_flood(flood);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_last: busy=%b, want 1", busy);
    end
    while (out_ready !== 1'b1 && w < 4) begin
      @(negedge clk);
      drive_flood(flood);
      w++;
    end
    total++;
    if (out_ready !== 1'b1 || w != 1) begin
      bad++;
      $display("FAIL drain_latency: waited=%0d out_ready=%b, want 1 1", w, out_ready);
      in_enable = 1'b0;
      return;
    end
    for (int k = 0; k < NP; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (k < NP - 1) drive_flood(flood);
      end
      if (k == NP - 1) in_enable = 1'b0;
      got = {out_ready, frame_done, busy, out_count_y, out_count_x, out_data};
      exp = {1'b1, (k == NP - 1), (k != NP - 1), 3'(k / W), 3'(k % W), mem_m[k]};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL beat%0d: {rdy,done,busy,y,x,data} got %h, want %h", k, got, exp);
      end
    end
    @(negedge clk);
    total++;
    if (out_ready !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL burst_end: rdy=%b done=%b busy=%b, want 0 0 0", out_ready, frame_done, busy);
    end
  endtask

  task automatic push_px(input int x, input int y, input int d);
    qx.push_back(x); qy.push_back(y); qd.push_back(d);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_enable = 1'b0; in_data = '0; in_count_x = '0; in_count_y = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({out_ready, out_data, out_count_x, out_count_y, busy, frame_done} !== '0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b data=%h x=%0d y=%0d busy=%b done=%b, want all 0",
               out_ready, out_data, out_count_x, out_count_y, busy, frame_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_raster(input int gap_max);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) push_px(x, y, 4 * y + x);
    send_frame(gap_max);
    drain_check(1'b0);
  endtask

  task automatic test_mirror;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) push_px(W - 1 - x, y, 4 * y + x);
    send_frame(0);
    drain_check(1'b0);
  endtask

  task automatic test_out_of_range;
    for (int i = 0; i < NP; i++) begin
      if (i == 3) push_px(4, 1, 8'hAA);
      if (i == 7) push_px(0, 3, 8'hBB);
      if (i == 10) push_px(7, 7, 8'hCC);
      push_px(i % W, i / W, $urandom_range(8'h90, 0));
    end
    send_frame(1);
    drain_check(1'b0);
  endtask

  task automatic test_ignore_during_drain;
    for (int i = 0; i < NP; i++) push_px(i % W, i / W, $urandom_range(8'hFE, 0));
    send_frame(0);
    drain_check(1'b1);
    for (int i = NP - 1; i >= 0; i--) push_px(i % W, i / W, $urandom_range(8'hFE, 0));
    send_frame(0);
    drain_check(1'b0);
  endtask

  task automatic test_reset_mid_drain;
    int w, beats;
    for (int i = 0; i < NP; i++) push_px(i % W, i / W, 8'h40 + i);
    send_frame(0);
    @(negedge clk);
    in_enable = 1'b0;
    w = 0;
    while (out_ready !== 1'b1 && w < 4) begin @(negedge clk); w++; end
    total++;
    if (out_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_drain_start: out_ready=%b, want 1", out_ready);
    end
    beats = 0;
    while (beats < 5) begin @(negedge clk); beats++; end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_ready !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || out_data !== 8'h00) begin
      bad++;
      $display("FAIL rst_async: rdy=%b busy=%b done=%b data=%h, want 0 0 0 00",
               out_ready, busy, frame_done, out_data);
    end
    @(negedge clk);
    total++;
    if (out_ready !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_hold: rdy=%b busy=%b done=%b, want 0 0 0", out_ready, busy, frame_done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < NP; i++) push_px(i % W, i / W, 8'h80 + 3 * i);
    send_frame(3);
    drain_check(1'b0);
  endtask

  task automatic test_random;
    int acc;
    for (int f = 0; f < 3; f++) begin
      acc = 0;
      while (acc < NP) begin
        int x, y;
        x = $urandom_range(W, 0);
        y = $urandom_range(H, 0);
        push_px(x, y, $urandom_range(255, 0));
        if (x < W && y < H) acc++;
      end
      send_frame(2);
      drain_check(f[0]);
    end
  endtask

  initial begin
    test_reset();
    test_raster(0);
    test_mirror();
    test_out_of_range();
    test_ignore_during_drain();
    test_reset_mid_drain();
    test_raster(3);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
